bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter sharing the single system-bus master port between N bus masters: camera grabber, DMA, CPU-side copy engine.
- Consumes each master's requestBus, drives one-hot busGrant.
- Tracks bus ownership by monitoring the shared beginTransaction/endTransaction/busError signals.
- A watchdog revokes a grant that is never used, so a stalled master cannot lock the bus.

Parameters:
- nrOfMasters, 4, number of requesters; legal range 2..8.
- grantTimeout, 16, cycles a granted master may take to assert beginTransactionIn before the grant is revoked; legal range 2..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- requestBus  input  nrOfMasters  per-master bus request; bit i = master i.
- beginTransactionIn  input  1  shared bus begin strobe (OR of all masters).
- endTransactionIn  input  1  shared bus end strobe.
- busErrorIn  input  1  bus error from slave side.
- busGrant  output  nrOfMasters  one-hot grant, registered.
- grantIndex  output  clog2(nrOfMasters)  index of current/last owner, registered.
- busActive  output  1  high while a granted transaction is in progress (ACTIVE state).
- timeoutError  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset values (reset==0 at a clock edge):
  - busGrant=0, grantIndex=0, busActive=0, timeoutError=0.
  - State IDLE.
  - Priority pointer lastOwner=nrOfMasters-1, so master 0 wins first.
  - Timeout counter=0.
- Reset has priority over every other event. Asserting reset in any state forces the reset values at the next edge and drops any grant immediately; no end-of-transaction handshake is issued.
- States: IDLE, GRANT, ACTIVE, RELEASE.
- IDLE:
  - If requestBus!=0, select the first requesting index, searching lastOwner+1, lastOwner+2, … modulo nrOfMasters.
  - Next edge: busGrant=one-hot(sel), grantIndex=sel, lastOwner=sel, timeout counter=grantTimeout-1, state GRANT.
  - If requestBus==0, stay in IDLE with busGrant=0.
  - Latency: request sampled in cycle t gives grant high in cycle t+1.
- GRANT:
  - busGrant is held regardless of requestBus; masters may drop their request once granted.
  - If beginTransactionIn=1:
    - with endTransactionIn=0 and busErrorIn=0 → ACTIVE, busActive=1 next cycle;
    - with endTransactionIn=1 or busErrorIn=1 in the same cycle → RELEASE.
  - Else if counter==0 → RELEASE, timeoutError=1 for exactly the next cycle, busGrant=0 next cycle.
  - Else the counter decrements.
  - If beginTransactionIn and counter==0 occur in the same cycle, begin wins and there is no timeout.
- ACTIVE:
  - busGrant and busActive are held.
  - No watchdog; bursts may be arbitrarily long under busy.
  - endTransactionIn=1 or busErrorIn=1 → RELEASE. busGrant=0 and busActive=0 next cycle.
  - beginTransactionIn while ACTIVE is ignored (protocol error, no state change).
- RELEASE:
  - busGrant=0 for exactly one cycle (bus turnaround), then IDLE unconditionally.
  - Back-to-back ownership is therefore: end in cycle t, grant low t+1, IDLE t+2, new grant t+3.
- Fairness:
  - lastOwner updates only on grant issue.
  - A master requesting continuously gets the bus at most once per nrOfMasters grants while others request.
  - A lone requester is re-granted every time; pointer wrap-around is modulo nrOfMasters.
- grantIndex keeps the last owner's value in IDLE/RELEASE. busGrant==0 is the only "no owner" indication.
- busGrant is always one-hot or zero, never multi-hot.
- timeoutError is a single-cycle pulse; it is never high outside the cycle after a GRANT→RELEASE timeout transition.
- Implementation size: one registered FSM plus a rotate/priority-encode selector, within 120–400 lines of RTL.

Test Plan:
- Single request (nrOfMasters=4, reset released, reset back to 1):
  - requestBus=0001 at cycle 0 → busGrant=0001 at cycle 1.
  - begin at cycle 3 → busActive=1 at cycle 4.
  - end at cycle 10 → busGrant=0 at cycle 11, IDLE at cycle 12.
- Round-robin: requestBus=1111 held, each grant completed with begin then end → grant order 0001, 0010, 0100, 1000, 0001; each grant is separated by one RELEASE cycle.
- Watchdog (grantTimeout=16): request from master 2, never begin → busGrant=0100 for cycles 1..16, busGrant=0 at cycle 17, timeoutError=1 at cycle 17 only; the next request from master 3 is granted before master 2.
- Simultaneous events:
  - begin with counter==0 → ACTIVE, no timeoutError.
  - begin+end in the same GRANT cycle → RELEASE, busActive never asserted.
  - busErrorIn in ACTIVE → RELEASE, same as end.
- Reset mid-operation: reset=0 during ACTIVE with busGrant=0010 → next edge busGrant=0, busActive=0, pointer restored; after release, requestBus=0011 grants master 0 first.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the shared system-bus master port, with an unused-grant watchdog.
// Latency: request sampled in cycle t gives a registered one-hot grant in cycle t+1; a one-cycle turnaround follows every release.
// Backpressure: the owner holds the bus until end/error; a grant never answered by begin is revoked after grantTimeout cycles.
module bus_arbiter_rr #(
    parameter int nrOfMasters  = 4,
    parameter int grantTimeout = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [nrOfMasters-1:0]         requestBus,
    input  logic                           beginTransactionIn,
    input  logic                           endTransactionIn,
    input  logic                           busErrorIn,
    output logic [nrOfMasters-1:0]         busGrant,
    output logic [$clog2(nrOfMasters)-1:0] grantIndex,
    output logic                           busActive,
    output logic                           timeoutError
);

    localparam int IW = $clog2(nrOfMasters);
    localparam logic [7:0] TIMER_INIT = 8'(grantTimeout - 1);
    localparam logic [nrOfMasters-1:0] ONE_HOT0 = {{(nrOfMasters-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] LAST_INIT = IW'(nrOfMasters - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [nrOfMasters-1:0] grant_q, grant_d;
    logic [IW-1:0]          index_q, index_d;
    logic [IW-1:0]          last_owner_q, last_owner_d;
    logic [7:0]             timer_q, timer_d;
    logic                   active_q, active_d;
    logic                   timeout_q, timeout_d;

    logic                   sel_vld;
    logic [IW-1:0]          sel_idx;
    logic [IW-1:0]          cand_idx;
    int                     cand;
    logic                   done_evt;

    // Walk offsets from farthest to nearest so the closest requester after lastOwner wins.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = nrOfMasters; k >= 1; k--) begin
            cand = int'(last_owner_q) + k;
            if (cand >= nrOfMasters) begin
                cand = cand - nrOfMasters;
            end
            cand_idx = IW'(cand);
            if (requestBus[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    assign done_evt = endTransactionIn | busErrorIn;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        index_d      = index_q;
        last_owner_d = last_owner_q;
        timer_d      = timer_q;
        active_d     = active_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (sel_vld) begin
                    grant_d      = ONE_HOT0 << sel_idx;
                    index_d      = sel_idx;
                    last_owner_d = sel_idx;
                    timer_d      = TIMER_INIT;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A begin on the watchdog's last cycle still counts as a valid start.
                if (beginTransactionIn) begin
                    if (done_evt) begin
                        grant_d = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        active_d = 1'b1;
                        state_d  = ST_ACTIVE;
                    end
                end else if (timer_q == 8'd0) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (done_evt) begin
                    grant_d  = '0;
                    active_d = 1'b0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            index_q      <= '0;
            last_owner_q <= LAST_INIT;
            timer_q      <= 8'd0;
            active_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            index_q      <= index_d;
            last_owner_q <= last_owner_d;
            timer_q      <= timer_d;
            active_q     <= active_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busGrant     = grant_q;
    assign grantIndex   = index_q;
    assign busActive    = active_q;
    assign timeoutError = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed-vector bench for bus_arbiter_rr with four masters and a 16-cycle grant watchdog.
module tb_bus_arbiter_rr;

    logic       clock;
    logic       reset;
    logic [3:0] requestBus;
    logic       beginTransactionIn;
    logic       endTransactionIn;
    logic       busErrorIn;
    logic [3:0] busGrant;
    logic [1:0] grantIndex;
    logic       busActive;
    logic       timeoutError;

    int tests_run    = 0;
    int tests_failed = 0;

    bus_arbiter_rr #(
        .nrOfMasters (4),
        .grantTimeout(16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .requestBus        (requestBus),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn  (endTransactionIn),
        .busErrorIn        (busErrorIn),
        .busGrant          (busGrant),
        .grantIndex        (grantIndex),
        .busActive         (busActive),
        .timeoutError      (timeoutError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to the next cycle; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        requestBus         = 4'b0000;
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        busErrorIn         = 1'b0;
        reset              = 1'b0;
        tick();
        tick();
        tests_run++;
        if (busGrant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_grant got=%b want=0000", busGrant);
        end
        tests_run++;
        if ({grantIndex, busActive, timeoutError} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs idx=%0d active=%b timeout=%b want 0/0/0", grantIndex, busActive, timeoutError);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        requestBus = 4'b0001;
        tick();
        requestBus = 4'b0000;
        tests_run++;
        if (busGrant !== 4'b0001 || grantIndex !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_grant got=%b idx=%0d want=0001 idx=0", busGrant, grantIndex);
        end
        tick();
        tick();
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        tests_run++;
        if (busActive !== 1'b1 || busGrant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_active active=%b grant=%b want 1/0001", busActive, busGrant);
        end
        repeat (6) tick();
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        tests_run++;
        if (busGrant !== 4'b0000 || busActive !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release grant=%b active=%b want 0000/0", busGrant, busActive);
        end
        requestBus = 4'b0001;
        tick();
        tests_run++;
        if (busGrant !== 4'b0000 || grantIndex !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_idle grant=%b idx=%0d want 0000 idx=0", busGrant, grantIndex);
        end
        tick();
        requestBus = 4'b0000;
        tests_run++;
        if (busGrant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_regrant got=%b want=0001", busGrant);
        end
        endTransactionIn   = 1'b1;
        beginTransactionIn = 1'b1;
        tick();
        endTransactionIn   = 1'b0;
        beginTransactionIn = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [5];
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        do_reset();
        requestBus = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            tests_run++;
            if (busGrant !== exp_order[g]) begin
                tests_failed++;
                $display("FAIL rr_grant%0d got=%b want=%b", g, busGrant, exp_order[g]);
            end
            beginTransactionIn = 1'b1;
            tick();
            beginTransactionIn = 1'b0;
            endTransactionIn   = 1'b1;
            tick();
            endTransactionIn   = 1'b0;
            tests_run++;
            if (busGrant !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_turnaround%0d got=%b want=0000", g, busGrant);
            end
            tick();
        end
        requestBus = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog();
        int bad_cycles;
        bad_cycles = 0;
        do_reset();
        requestBus = 4'b0100;
        tick();
        requestBus = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            if (busGrant !== 4'b0100 || timeoutError !== 1'b0) bad_cycles++;
            tick();
        end
        tests_run++;
        if (bad_cycles !== 0) begin
            tests_failed++;
            $display("FAIL wd_hold bad_cycles=%0d want=0", bad_cycles);
        end
        tests_run++;
        if (busGrant !== 4'b0000 || timeoutError !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_revoke grant=%b timeout=%b want 0000/1", busGrant, timeoutError);
        end
        requestBus = 4'b1100;
        tick();
        tests_run++;
        if (timeoutError !== 1'b0 || busGrant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL wd_pulse timeout=%b grant=%b want 0/0000", timeoutError, busGrant);
        end
        tick();
        requestBus = 4'b0000;
        tests_run++;
        if (busGrant !== 4'b1000 || grantIndex !== 2'd3) begin
            tests_failed++;
            $display("FAIL wd_next_owner got=%b idx=%0d want=1000 idx=3", busGrant, grantIndex);
        end
        beginTransactionIn = 1'b1;
        endTransactionIn   = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        tests_run++;
        if (busGrant !== 4'b0000 || busActive !== 1'b0) begin
            tests_failed++;
            $display("FAIL begin_end_same grant=%b active=%b want 0000/0", busGrant, busActive);
        end
        tick();
        tests_run++;
        if (busActive !== 1'b0 || busGrant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL begin_end_idle grant=%b active=%b want 0000/0", busGrant, busActive);
        end
    endtask

    task automatic test_begin_at_zero();
        int bad_cycles;
        bad_cycles = 0;
        do_reset();
        requestBus = 4'b0001;
        tick();
        requestBus = 4'b0000;
        repeat (15) tick();
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        tests_run++;
        if (busActive !== 1'b1 || timeoutError !== 1'b0 || busGrant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL begin_at_zero active=%b timeout=%b grant=%b want 1/0/0001", busActive, timeoutError, busGrant);
        end
        for (int c = 0; c < 24; c++) begin
            tick();
            if (busActive !== 1'b1 || timeoutError !== 1'b0 || busGrant !== 4'b0001) bad_cycles++;
        end
        tests_run++;
        if (bad_cycles !== 0) begin
            tests_failed++;
            $display("FAIL long_burst bad_cycles=%0d want=0", bad_cycles);
        end
        busErrorIn = 1'b1;
        tick();
        busErrorIn = 1'b0;
        tests_run++;
        if (busGrant !== 4'b0000 || busActive !== 1'b0 || timeoutError !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_release grant=%b active=%b timeout=%b want 0000/0/0", busGrant, busActive, timeoutError);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        requestBus = 4'b0010;
        tick();
        requestBus = 4'b0000;
        beginTransactionIn = 1'b1;
        tick();
        tick();
        beginTransactionIn = 1'b0;
        tests_run++;
        if (busActive !== 1'b1 || busGrant !== 4'b0010 || grantIndex !== 2'd1) begin
            tests_failed++;
            $display("FAIL mid_active active=%b grant=%b idx=%0d want 1/0010/1", busActive, busGrant, grantIndex);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++;
        if (busGrant !== 4'b0000 || busActive !== 1'b0 || grantIndex !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_reset grant=%b active=%b idx=%0d want 0000/0/0", busGrant, busActive, grantIndex);
        end
        requestBus = 4'b0011;
        tick();
        requestBus = 4'b0000;
        tests_run++;
        if (busGrant !== 4'b0001 || grantIndex !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_pointer got=%b idx=%0d want=0001 idx=0", busGrant, grantIndex);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_begin_at_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
